// File: rtl/uart_tx_arbiter_if.sv
// Byte-write and UART-emitter handshake bundle for uart_tx_arbiter.
// Ports: a_/b_ valid,data in; a_/b_ full,ovf out; uart_data/valid out, uart_ready in.
interface uart_tx_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_full;
    logic       a_ovf;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_full;
    logic       b_ovf;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, uart_ready,
        output a_full, a_ovf, b_full, b_ovf, uart_data, uart_valid
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, uart_ready,
        input  a_full, a_ovf, b_full, b_ovf, uart_data, uart_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-hart UART TX arbiter: per-hart byte FIFOs, round-robin grant, one-entry output stage.
// Ports: clk, resetn (async active-low), bus (uart_tx_arbiter_if.slave).
// Optional UART_LINE_LOCK_EN: hold the grant on one hart until '\n' or LOCK_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int DEPTH        = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    uart_tx_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_tmo
        $error("LOCK_TIMEOUT must be >= 1");
    end

    logic [1:0]      in_valid;
    logic [1:0][7:0] in_data;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      full;
    logic [1:0]      ne;
    logic [1:0]      ovf;
    logic [1:0][7:0] head;
    logic [1:0]      elig;

    assign in_valid = {bus.b_valid, bus.a_valid};
    assign in_data  = {bus.b_data, bus.a_data};

    for (genvar h = 0; h < 2; h++) begin : g_fifo
        logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [AW:0]   cnt_q, cnt_d;
        logic          ovf_q, ovf_d;
        logic [7:0]    mem_q [DEPTH];

        // Full is taken from the registered count, so a push that
        // coincides with a pop from a full FIFO is still dropped.
        assign full[h] = (cnt_q == (AW + 1)'(DEPTH));
        assign ne[h]   = (cnt_q != '0);
        assign push[h] = in_valid[h] && !full[h];
        assign head[h] = mem_q[rd_q];
        assign ovf[h]  = ovf_q;

        always_comb begin
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (push[h]) wr_d = wr_q + 1'b1;
            if (pop[h])  rd_d = rd_q + 1'b1;
            if (in_valid[h] && full[h]) ovf_d = 1'b1;
            case ({push[h], pop[h]})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[h]) mem_q[wr_q] <= in_data[h];
        end
    end

    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       last_q, last_d;
    logic       sel;
    logic       load;
    logic       stage_free;

    // Tie goes to the hart not served last; otherwise the only eligible one.
    always_comb begin
        if (&elig) sel = ~last_q;
        else       sel = elig[1];
    end

    assign stage_free = !out_valid_q || bus.uart_ready;
    assign load       = stage_free && (|elig);
    assign pop        = load ? (sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        if (stage_free) out_valid_d = load;
        if (load) begin
            out_data_d = head[sel];
            last_d     = sel;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

`ifdef UART_LINE_LOCK_EN
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;
    localparam int         TW        = $clog2(LOCK_TIMEOUT + 1);

    logic [1:0]    st_q, st_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          owner;

    assign owner = (st_q == ST_LOCK_B);

    always_comb begin
        case (st_q)
            ST_LOCK_A: elig = ne & 2'b01;
            ST_LOCK_B: elig = ne & 2'b10;
            default:   elig = ne;
        endcase
    end

    // A lone '\n' from IDLE does not open a lock; the timeout only
    // counts while the owner's FIFO stays empty.
    always_comb begin
        st_d  = st_q;
        tmo_d = '0;
        if (st_q == ST_IDLE) begin
            if (load && head[sel] != 8'h0A)
                st_d = sel ? ST_LOCK_B : ST_LOCK_A;
        end else if (load && head[sel] == 8'h0A) begin
            st_d = ST_IDLE;
        end else if (!ne[owner]) begin
            if (tmo_q == TW'(LOCK_TIMEOUT - 1)) st_d = ST_IDLE;
            else tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q  <= ST_IDLE;
            tmo_q <= '0;
        end else begin
            st_q  <= st_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign elig = ne;
`endif

    assign bus.a_full     = full[0];
    assign bus.b_full     = full[1];
    assign bus.a_ovf      = ovf[0];
    assign bus.b_ovf      = ovf[1];
    assign bus.uart_valid = out_valid_q;
    assign bus.uart_data  = out_data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes queued at stimulus,
// popped and compared on every UART transfer.
module tb_uart_tx_arbiter;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .DEPTH(DEPTH),
        .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          xfers = 0;
    int          x0;
    logic [7:0]  exp_q [$];
    logic [15:0] mon_exp;

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.uart_valid && bus.uart_ready) begin
            xfers++;
            if (exp_q.size() != 0) mon_exp = {8'h00, exp_q.pop_front()};
            else mon_exp = 'x;
            chk("uart_data", {8'h00, bus.uart_data}, mon_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(logic va, logic [7:0] da, logic vb, logic [7:0] db);
        bus.a_valid = va;
        bus.a_data  = da;
        bus.b_valid = vb;
        bus.b_data  = db;
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic drain(int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain_left", 16'(exp_q.size()), 16'd0);
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        exp_q.delete();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        bus.a_valid    = 1'b0;
        bus.a_data     = 8'h00;
        bus.b_valid    = 1'b0;
        bus.b_data     = 8'h00;
        bus.uart_ready = 1'b0;
        #2;
        chk("rst_valid", {15'd0, bus.uart_valid}, 16'd0);
        chk("rst_data", {8'h00, bus.uart_data}, 16'd0);
        chk("rst_a_full", {15'd0, bus.a_full}, 16'd0);
        chk("rst_b_full", {15'd0, bus.b_full}, 16'd0);
        chk("rst_a_ovf", {15'd0, bus.a_ovf}, 16'd0);
        chk("rst_b_ovf", {15'd0, bus.b_ovf}, 16'd0);
        tick();
        tick();
        resetn = 1'b1;

        // tie: A first after reset, then alternate
        bus.uart_ready = 1'b1;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h62);
        push2(1'b1, 8'h41, 1'b1, 8'h61);
        push2(1'b1, 8'h42, 1'b1, 8'h62);
        drain(20);

        // latency: push on edge N, valid after N+1
        exp_q.push_back(8'h11);
        push2(1'b1, 8'h11, 1'b0, 8'h00);
        chk("lat_n", {15'd0, bus.uart_valid}, 16'd0);
        tick();
        chk("lat_n1", {15'd0, bus.uart_valid}, 16'd1);
        chk("lat_data", {8'h00, bus.uart_data}, 16'h0011);
        tick();

        // throughput: 8 back-to-back pushes, 8 transfers in 8 cycles
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            push2(1'b1, 8'(8'h20 + i), 1'b0, 8'h00);
            if (i == 1) x0 = xfers;
        end
        tick();
        tick();
        chk("thru", 16'(xfers - x0), 16'd8);
        chk("thru_left", 16'(exp_q.size()), 16'd0);

        // back-pressure on A
        bus.uart_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'(8'hB0 + i));
            push2(1'b1, 8'(8'hB0 + i), 1'b0, 8'h00);
            if (i == 3) chk("bp_full4", {15'd0, bus.a_full}, 16'd0);
        end
        chk("bp_full5", {15'd0, bus.a_full}, 16'd1);
        chk("bp_valid", {15'd0, bus.uart_valid}, 16'd1);
        chk("bp_ovf0", {15'd0, bus.a_ovf}, 16'd0);
        push2(1'b1, 8'hB5, 1'b0, 8'h00);
        chk("bp_ovf", {15'd0, bus.a_ovf}, 16'd1);
        chk("bp_hold", {8'h00, bus.uart_data}, 16'h00B0);
        bus.uart_ready = 1'b1;
        drain(20);
        chk("bp_unfull", {15'd0, bus.a_full}, 16'd0);
        chk("bp_sticky", {15'd0, bus.a_ovf}, 16'd1);
        chk("bp_b_ovf", {15'd0, bus.b_ovf}, 16'd0);

        // reset mid-stream
        bus.uart_ready = 1'b0;
        push2(1'b1, 8'hC0, 1'b1, 8'hC1);
        push2(1'b1, 8'hC2, 1'b1, 8'hC3);
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_valid", {15'd0, bus.uart_valid}, 16'd0);
        chk("mrst_data", {8'h00, bus.uart_data}, 16'd0);
        chk("mrst_a_ovf", {15'd0, bus.a_ovf}, 16'd0);
        chk("mrst_a_full", {15'd0, bus.a_full}, 16'd0);
        chk("mrst_b_full", {15'd0, bus.b_full}, 16'd0);
        tick();
        resetn = 1'b1;
        bus.uart_ready = 1'b1;
        x0 = xfers;
        repeat (5) tick();
        chk("no_stale", 16'(xfers - x0), 16'd0);
        chk("stale_valid", {15'd0, bus.uart_valid}, 16'd0);

`ifdef UART_LINE_LOCK_EN
        // interleaved lines come out whole
        do_reset();
        bus.uart_ready = 1'b1;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h79);
        exp_q.push_back(8'h0A);
        push2(1'b1, 8'h41, 1'b1, 8'h78);
        push2(1'b1, 8'h42, 1'b1, 8'h79);
        push2(1'b1, 8'h0A, 1'b1, 8'h0A);
        drain(40);

        // unterminated line: B waits out the timeout
        do_reset();
        bus.uart_ready = 1'b1;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h79);
        push2(1'b1, 8'h41, 1'b1, 8'h78);
        push2(1'b1, 8'h42, 1'b1, 8'h79);
        repeat (TMO + 1) tick();
        chk("tmo_hold", {15'd0, bus.uart_valid}, 16'd0);
        tick();
        chk("tmo_rel", {15'd0, bus.uart_valid}, 16'd1);
        drain(20);
`endif

        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-hart byte FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, idle cycles that release a line lock (used only with the macro in REQ-024).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a_valid  in  1  hart A byte write strobe (UART data register store).
REQ-006 SHALL have port a_data  in  8  hart A byte.
REQ-007 SHALL have port a_full  out  1  hart A FIFO full (CPU busy-poll bit).
REQ-008 SHALL have port a_ovf  out  1  sticky: hart A write dropped.
REQ-009 SHALL have ports b_valid, b_data, b_full, b_ovf, same directions, widths and meanings for hart B.
REQ-010 SHALL have port uart_data  out  8  byte to UART emitter.
REQ-011 SHALL have port uart_valid  out  1  uart_data valid.
REQ-012 SHALL have port uart_ready  in  1  emitter accepts; transfer = uart_valid && uart_ready on a rising edge.

Function
REQ-013 SHALL push x_data into FIFO x on an edge where x_valid=1 and x_full=0.
REQ-014 SHALL drop the byte and set x_ovf=1 when x_valid=1 and x_full=1; full is evaluated before any same-cycle pop, so push-while-full-and-popping is still dropped.
REQ-015 SHALL drive x_full=1 exactly when FIFO x holds DEPTH bytes; pointers wrap modulo DEPTH, occupancy count width log2(DEPTH)+1.
REQ-016 SHALL register uart_data/uart_valid in a one-entry output stage loaded from the granted FIFO head when the stage is empty or transferring that edge.
REQ-017 SHALL keep uart_data stable and uart_valid=1 while uart_valid=1 and uart_ready=0.
REQ-018 SHALL make a byte pushed on edge N into an empty FIFO, with an empty output stage, appear with uart_valid=1 after edge N+1.
REQ-019 SHALL sustain one byte per cycle when uart_ready is held 1 and a FIFO is non-empty.
REQ-020 SHALL grant round-robin per byte: both FIFOs non-empty -> the hart not served last; one non-empty -> that hart; none -> output stage not loaded.
REQ-021 SHALL clear uart_valid after a transfer edge when no FIFO is eligible.
REQ-022 SHALL never reorder bytes within one hart and never lose an accepted byte.

Reset
REQ-023 SHALL, on resetn=0 at any time including mid-transfer, asynchronously clear FIFOs, output stage (uart_valid=0, uart_data=0), a_ovf=b_ovf=0, a_full=b_full=0, last-served=B (A wins first tie), lock state=IDLE, timeout counter=0.

Configuration
REQ-024 SHALL, with macro UART_LINE_LOCK_EN defined, add states IDLE, LOCK_A, LOCK_B: IDLE->LOCK_x when a byte from x loads the output stage; LOCK_x grants only x; LOCK_x->IDLE when x's byte 0x0A loads, or after FIFO x has been empty for LOCK_TIMEOUT consecutive cycles; the other hart's FIFO fills and back-pressures via x_full meanwhile.
REQ-025 SHALL, without UART_LINE_LOCK_EN, implement per-byte round-robin only (REQ-020), with no lock state or timeout counter.

Verification
REQ-026 SHALL verify reset: resetn=0 mid-stream -> uart_valid=0, a_full=b_full=0, a_ovf=b_ovf=0 immediately, no stale byte after release.
REQ-027 SHALL verify tie: A pushes 0x41,0x42; B pushes 0x61,0x62 same cycles, uart_ready=1 -> UART sees 0x41,0x61,0x42,0x62 (macro off).
REQ-028 SHALL verify back-pressure: uart_ready=0, A pushes 5 bytes at DEPTH=4 -> one byte in output stage, a_full=1 after 5th edge; 6th push dropped, a_ovf=1; all 5 accepted bytes emerge in order when uart_ready=1.
REQ-029 SHALL verify latency/throughput: single push on edge N -> uart_valid=1 after N+1; continuous pushes with uart_ready=1 -> one transfer per cycle.
REQ-030 SHALL verify line lock (macro on): A sends "AB\n", B sends "xy\n" interleaved -> UART sees "AB\nxy\n"; A sends "AB" without newline -> lock released LOCK_TIMEOUT cycles after A's FIFO empties, then B drains.
